// File: rtl/hazard_control_unit.sv
// ID-stage hazard control: load-use (multi-cycle), ID-branch operand, HI/LO busy stalls,
// plus IF/ID flush gating and a saturating stall-cycle counter.
module hazard_control_unit #(
  parameter int REG_W    = 5,
  parameter int LOAD_LAT = 1,
  parameter int MD_LAT   = 4,
  parameter int STAT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        id_ex_memread,
  input  logic [REG_W-1:0]  id_ex_rt,
  input  logic              id_ex_regwrite,
  input  logic [REG_W-1:0]  id_ex_rd,
  input  logic              ex_mem_memread,
  input  logic [REG_W-1:0]  ex_mem_rd,
  input  logic [REG_W-1:0]  if_id_rs,
  input  logic [REG_W-1:0]  if_id_rt,
  input  logic              if_id_uses_rt,
  input  logic              if_id_branch,
  input  logic              if_id_md_read,
  input  logic              md_start,
  input  logic              branch_taken,
  output logic              stall,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              if_id_flush,
  output logic [STAT_W-1:0] stall_count
);

  // load_cnt only ever holds LOAD_LAT-1 down to 0
  localparam int LD_W = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;
  localparam int MD_W = $clog2(MD_LAT + 1);
  localparam logic [LD_W-1:0] LD_INIT = LD_W'(LOAD_LAT - 1);
  localparam logic [MD_W-1:0] MD_INIT = MD_W'(MD_LAT);

  typedef enum logic {L_IDLE, L_WAIT} ld_state_t;

  ld_state_t       ld_state, ld_state_nxt;
  logic [LD_W-1:0] load_cnt, load_cnt_nxt;
  logic [MD_W-1:0] md_cnt;
  logic            h_load, h_br, h_md;

  // register $0 never carries a real dependency
  function automatic logic src_hit(input logic [REG_W-1:0] dst);
    src_hit = (dst != '0) &&
              ((dst == if_id_rs) || (if_id_uses_rt && (dst == if_id_rt)));
  endfunction

  assign h_load = (id_ex_memread != 2'b00) && src_hit(id_ex_rt);
  assign h_br   = if_id_branch &&
                  ((id_ex_regwrite && src_hit(id_ex_rd)) ||
                   (ex_mem_memread && src_hit(ex_mem_rd)));
  assign h_md   = if_id_md_read && (md_cnt != '0);

  assign stall       = h_load || (ld_state == L_WAIT) || h_br || h_md;
  assign pc_write    = ~stall;
  assign if_id_write = ~stall;
  // a branch resolved on stale operands must not squash the fetch
  assign if_id_flush = branch_taken && ~stall;

  always_comb begin
    ld_state_nxt = ld_state;
    load_cnt_nxt = load_cnt;
    case (ld_state)
      L_IDLE: begin
        if (h_load && (LOAD_LAT > 1)) begin
          ld_state_nxt = L_WAIT;
          load_cnt_nxt = LD_INIT;
        end
      end
      L_WAIT: begin
        load_cnt_nxt = load_cnt - LD_W'(1);
        if (load_cnt == LD_W'(1)) ld_state_nxt = L_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_state <= L_IDLE;
      load_cnt <= '0;
    end else begin
      ld_state <= ld_state_nxt;
      load_cnt <= load_cnt_nxt;
    end
  end

  // a new mult/div restarts the HI/LO busy window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              md_cnt <= '0;
    else if (md_start)       md_cnt <= MD_INIT;
    else if (md_cnt != '0)   md_cnt <= md_cnt - MD_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        stall_count <= '0;
    else if (stall && ~&stall_count)   stall_count <= stall_count + STAT_W'(1);
  end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Three parameterisations driven by shared stimulus, checked each cycle against a
// window/timestamp model of the stall rules.
module tb_hazard_control_unit;
  localparam int NC     = 3;
  localparam int MD_LAT = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] id_ex_memread;
  logic [4:0] id_ex_rt, id_ex_rd, ex_mem_rd, if_id_rs, if_id_rt;
  logic id_ex_regwrite, ex_mem_memread, if_id_uses_rt, if_id_branch;
  logic if_id_md_read, md_start, branch_taken;
  logic [NC-1:0] stall, pc_write, if_id_write, if_id_flush;
  logic [15:0] cnt_a, cnt_b;
  logic [1:0]  cnt_c;

  int total = 0;
  int bad = 0;
  int cyc;
  int md_end;
  int ld_end [NC];
  int cnt [NC];

  always #5 clk = ~clk;

  hazard_control_unit #(.REG_W(5), .LOAD_LAT(1), .MD_LAT(MD_LAT), .STAT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .id_ex_memread(id_ex_memread), .id_ex_rt(id_ex_rt),
    .id_ex_regwrite(id_ex_regwrite), .id_ex_rd(id_ex_rd), .ex_mem_memread(ex_mem_memread),
    .ex_mem_rd(ex_mem_rd), .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
    .if_id_uses_rt(if_id_uses_rt), .if_id_branch(if_id_branch), .if_id_md_read(if_id_md_read),
    .md_start(md_start), .branch_taken(branch_taken), .stall(stall[0]), .pc_write(pc_write[0]),
    .if_id_write(if_id_write[0]), .if_id_flush(if_id_flush[0]), .stall_count(cnt_a));

  hazard_control_unit #(.REG_W(5), .LOAD_LAT(3), .MD_LAT(MD_LAT), .STAT_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .id_ex_memread(id_ex_memread), .id_ex_rt(id_ex_rt),
    .id_ex_regwrite(id_ex_regwrite), .id_ex_rd(id_ex_rd), .ex_mem_memread(ex_mem_memread),
    .ex_mem_rd(ex_mem_rd), .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
    .if_id_uses_rt(if_id_uses_rt), .if_id_branch(if_id_branch), .if_id_md_read(if_id_md_read),
    .md_start(md_start), .branch_taken(branch_taken), .stall(stall[1]), .pc_write(pc_write[1]),
    .if_id_write(if_id_write[1]), .if_id_flush(if_id_flush[1]), .stall_count(cnt_b));

  hazard_control_unit #(.REG_W(5), .LOAD_LAT(1), .MD_LAT(MD_LAT), .STAT_W(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .id_ex_memread(id_ex_memread), .id_ex_rt(id_ex_rt),
    .id_ex_regwrite(id_ex_regwrite), .id_ex_rd(id_ex_rd), .ex_mem_memread(ex_mem_memread),
    .ex_mem_rd(ex_mem_rd), .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
    .if_id_uses_rt(if_id_uses_rt), .if_id_branch(if_id_branch), .if_id_md_read(if_id_md_read),
    .md_start(md_start), .branch_taken(branch_taken), .stall(stall[2]), .pc_write(pc_write[2]),
    .if_id_write(if_id_write[2]), .if_id_flush(if_id_flush[2]), .stall_count(cnt_c));

  function automatic int lat(input int k);
    return (k == 1) ? 3 : 1;
  endfunction

  function automatic int cnt_max(input int k);
    return (k == 2) ? 3 : 65535;
  endfunction

  function automatic logic [31:0] obs_cnt(input int k);
    if (k == 0) return 32'(cnt_a);
    if (k == 1) return 32'(cnt_b);
    return 32'(cnt_c);
  endfunction

  function automatic bit reads(input logic [4:0] dst);
    return (dst != 0) && (dst == if_id_rs || (if_id_uses_rt && dst == if_id_rt));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    cyc = 0;
    md_end = -1;
    for (int k = 0; k < NC; k++) begin
      ld_end[k] = -1;
      cnt[k] = 0;
    end
  endtask

  task automatic set_idle();
    id_ex_memread = 2'b00; id_ex_rt = 0; id_ex_regwrite = 0; id_ex_rd = 0;
    ex_mem_memread = 0; ex_mem_rd = 0; if_id_rs = 0; if_id_rt = 0;
    if_id_uses_rt = 0; if_id_branch = 0; if_id_md_read = 0; md_start = 0; branch_taken = 0;
  endtask

  // Called with inputs settled, before the next rising edge; ends on the following negedge.
  task automatic run_cycle();
    bit hl, hb, hm, st [NC];
    hl = (id_ex_memread != 0) && reads(id_ex_rt);
    hb = if_id_branch && ((id_ex_regwrite && reads(id_ex_rd)) ||
                          (ex_mem_memread && reads(ex_mem_rd)));
    hm = if_id_md_read && (cyc <= md_end);
    for (int k = 0; k < NC; k++) begin
      st[k] = hl || (cyc <= ld_end[k]) || hb || hm;
      check($sformatf("stall[%0d]@%0d", k, cyc), 32'(stall[k]), 32'(st[k]));
      check($sformatf("pc_write[%0d]@%0d", k, cyc), 32'(pc_write[k]), 32'(!st[k]));
      check($sformatf("if_id_write[%0d]@%0d", k, cyc), 32'(if_id_write[k]), 32'(!st[k]));
      check($sformatf("flush[%0d]@%0d", k, cyc), 32'(if_id_flush[k]), 32'(branch_taken && !st[k]));
      check($sformatf("count[%0d]@%0d", k, cyc), obs_cnt(k), 32'(cnt[k]));
    end
    @(posedge clk);
    for (int k = 0; k < NC; k++) begin
      if (st[k] && cnt[k] < cnt_max(k)) cnt[k]++;
      if (hl && cyc > ld_end[k]) ld_end[k] = cyc + lat(k) - 1;
    end
    if (md_start) md_end = cyc + MD_LAT;
    cyc++;
    @(negedge clk);
  endtask

  task automatic step();
    #1;
    run_cycle();
  endtask

  task automatic do_reset();
    @(negedge clk);
    set_idle();
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
  endtask

  initial begin
    set_idle();
    model_reset();

    // reset release, idle
    do_reset();
    #1;
    check("rst_stall", 32'(stall), 32'b000);
    check("rst_pcw", 32'(pc_write), 32'b111);
    check("rst_cnt_a", 32'(cnt_a), 32'd0);
    run_cycle();
    step();

    // load-use on $8, load leaves EX after one cycle
    id_ex_memread = 2'b01; id_ex_rt = 8; if_id_rs = 8;
    step();
    set_idle();
    repeat (4) step();
    check("ld_cnt_a", 32'(cnt_a), 32'd1);
    check("ld_cnt_b", 32'(cnt_b), 32'd3);

    // $0 never matches
    id_ex_memread = 2'b01; id_ex_rt = 0; if_id_rs = 0;
    #1;
    check("zero_reg_stall", 32'(stall), 32'b000);
    run_cycle();
    set_idle();

    // rt only compared when used
    id_ex_memread = 2'b10; id_ex_rt = 5; if_id_rs = 1; if_id_rt = 5; if_id_uses_rt = 0;
    step();
    if_id_uses_rt = 1;
    step();
    set_idle();
    repeat (3) step();

    // branch operand hazards and flush gating
    do_reset();
    if_id_branch = 1; if_id_rs = 9; id_ex_regwrite = 1; id_ex_rd = 9;
    step();
    set_idle();
    step();
    if_id_branch = 1; if_id_rs = 9; id_ex_memread = 2'b01; id_ex_rt = 9;
    id_ex_regwrite = 1; id_ex_rd = 9; branch_taken = 1;
    step();
    id_ex_memread = 0; id_ex_regwrite = 0; ex_mem_memread = 1; ex_mem_rd = 9;
    #1;
    check("br_mem_stall_a", 32'(stall[0]), 32'd1);
    check("br_mem_flush_a", 32'(if_id_flush[0]), 32'd0);
    run_cycle();
    ex_mem_memread = 0;
    #1;
    check("br_free_flush_a", 32'(if_id_flush[0]), 32'd1);
    run_cycle();
    set_idle();
    repeat (3) step();

    // HI/LO busy window, then restart mid-window
    do_reset();
    md_start = 1;
    step();
    md_start = 0; if_id_md_read = 1;
    repeat (5) step();
    md_start = 1; if_id_md_read = 0;
    step();
    md_start = 0; if_id_md_read = 1;
    step();
    md_start = 1;
    step();
    md_start = 0;
    repeat (6) step();
    set_idle();

    // counter saturation on the 2-bit instance
    do_reset();
    if_id_branch = 1; if_id_rs = 3; id_ex_regwrite = 1; id_ex_rd = 3;
    repeat (5) step();
    set_idle();
    #1;
    check("sat_cnt_c", 32'(cnt_c), 32'd3);
    check("sat_cnt_a", 32'(cnt_a), 32'd5);
    run_cycle();

    // asynchronous reset while the 3-cycle load stall is in progress
    id_ex_memread = 2'b11; id_ex_rt = 7; if_id_rs = 7;
    step();
    set_idle();
    md_start = 1;
    step();
    md_start = 0;
    #1;
    check("wait_stall_b", 32'(stall[1]), 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_stall", 32'(stall), 32'b000);
    check("arst_cnt_b", 32'(cnt_b), 32'd0);
    if_id_md_read = 1;
    #1;
    check("arst_md", 32'(stall), 32'b000);
    set_idle();
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    step();

    // randomized traffic over a small register set to force collisions
    repeat (600) begin
      id_ex_memread  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      id_ex_rt       = 5'($urandom_range(0, 3));
      id_ex_regwrite = 1'($urandom_range(0, 1));
      id_ex_rd       = 5'($urandom_range(0, 3));
      ex_mem_memread = ($urandom_range(0, 3) == 0);
      ex_mem_rd      = 5'($urandom_range(0, 3));
      if_id_rs       = 5'($urandom_range(0, 3));
      if_id_rt       = 5'($urandom_range(0, 3));
      if_id_uses_rt  = 1'($urandom_range(0, 1));
      if_id_branch   = ($urandom_range(0, 2) == 0);
      if_id_md_read  = ($urandom_range(0, 2) == 0);
      md_start       = ($urandom_range(0, 9) == 0);
      branch_taken   = 1'($urandom_range(0, 1));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
